// File: rtl/router_fsm_pkg.sv
// Shared definitions for the 1x3 router control FSM: state encodings,
// header address constants and the Moore output decode.
package router_fsm_pkg;

    localparam int ADDR_W   = 2;
    localparam int NUM_DEST = 3;

    localparam logic [ADDR_W-1:0] ADDR_DISCARD = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    typedef struct packed {
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic laf_state;
        logic full_state;
        logic rst_int_reg;
        logic write_enb_reg;
        logic busy;
    } fsm_out_t;

    // Pure state decode; the top registers it against the next state so the
    // outputs line up with the state register.
    function automatic fsm_out_t decode_outputs(input state_e s);
        fsm_out_t o;
        o               = '0;
        o.detect_add    = (s == DECODE_ADDRESS);
        o.lfd_state     = (s == LOAD_FIRST_DATA);
        o.ld_state      = (s == LOAD_DATA);
        o.laf_state     = (s == LOAD_AFTER_FULL);
        o.full_state    = (s == FIFO_FULL_STATE);
        o.rst_int_reg   = (s == CHECK_PARITY_ERROR);
        o.write_enb_reg = (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
        o.busy          = (s != DECODE_ADDRESS) && (s != LOAD_DATA);
        return o;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: header decode, wait-for-empty, header/payload/parity
// sequencing and FIFO-full stall, with registered Moore outputs.
module router_fsm
    import router_fsm_pkg::*;
#(
    parameter int ADDR_W_P   = ADDR_W,
    parameter int NUM_DEST_P = NUM_DEST
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pkt_valid,
    input  logic [ADDR_W_P-1:0] data_in,
    input  logic                fifo_full,
    input  logic                fifo_empty_0,
    input  logic                fifo_empty_1,
    input  logic                fifo_empty_2,
    input  logic                soft_reset_0,
    input  logic                soft_reset_1,
    input  logic                soft_reset_2,
    input  logic                parity_done,
    input  logic                low_pkt_valid,
    output logic                detect_add,
    output logic                lfd_state,
    output logic                ld_state,
    output logic                laf_state,
    output logic                full_state,
    output logic                rst_int_reg,
    output logic                write_enb_reg,
    output logic                busy
);

    state_e              state, state_nxt;
    logic [ADDR_W_P-1:0] addr_q;
    fsm_out_t            outs_q;

    // Top slot pads the discard address so it reads as never-empty / no reset.
    logic [NUM_DEST_P:0] empty_v;
    logic [NUM_DEST_P:0] soft_v;
    logic                hdr_ok;

    assign empty_v = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_v  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    assign hdr_ok  = pkt_valid && (data_in != ADDR_DISCARD);

    always_comb begin
        state_nxt = state;
        case (state)
            DECODE_ADDRESS: begin
                if (hdr_ok)
                    state_nxt = empty_v[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_v[addr_q])
                    state_nxt = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
            LOAD_DATA: begin
                // Full takes precedence over end-of-packet; parity follows via LAF.
                if (fifo_full)
                    state_nxt = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    state_nxt = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    state_nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_nxt = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    state_nxt = LOAD_PARITY;
                else
                    state_nxt = LOAD_DATA;
            end
            LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_nxt = DECODE_ADDRESS;
        endcase

        if (state != DECODE_ADDRESS && soft_v[addr_q])
            state_nxt = DECODE_ADDRESS;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= DECODE_ADDRESS;
            addr_q <= '0;
            outs_q <= decode_outputs(DECODE_ADDRESS);
        end else begin
            state  <= state_nxt;
            outs_q <= decode_outputs(state_nxt);
            if (state == DECODE_ADDRESS && hdr_ok)
                addr_q <= data_in;
        end
    end

    assign detect_add    = outs_q.detect_add;
    assign lfd_state     = outs_q.lfd_state;
    assign ld_state      = outs_q.ld_state;
    assign laf_state     = outs_q.laf_state;
    assign full_state    = outs_q.full_state;
    assign rst_int_reg   = outs_q.rst_int_reg;
    assign write_enb_reg = outs_q.write_enb_reg;
    assign busy          = outs_q.busy;

endmodule

// File: tb/tb_router_fsm.sv
// Directed scoreboard bench for router_fsm: each step queues the expected
// output vector for the state the spec says the FSM must reach.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done, low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    int we_cnt;

    typedef enum int { S_DA, S_LFD, S_LD, S_LP, S_FFS, S_LAF, S_WTE, S_CPE } tb_state_e;

    router_fsm dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy)
    );

    always #5 clock = ~clock;

    // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    function automatic logic [7:0] exp_vec(input tb_state_e s);
        case (s)
            S_DA:    return 8'b1000_0000;
            S_LFD:   return 8'b0100_0001;
            S_LD:    return 8'b0010_0010;
            S_LAF:   return 8'b0001_0011;
            S_FFS:   return 8'b0000_1001;
            S_CPE:   return 8'b0000_0101;
            S_LP:    return 8'b0000_0011;
            default: return 8'b0000_0001; // WAIT_TILL_EMPTY
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Inputs are already applied; advance one clock and compare outputs.
    task automatic step(input string tag, input tb_state_e s);
        logic [7:0] got, exp;
        exp_q.push_back(exp_vec(s));
        @(posedge clock);
        #1;
        got = {detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy};
        if (write_enb_reg) we_cnt++;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        step("rst0", S_DA);
        step("rst1", S_DA);
        reset = 1'b0;

        // Discard address and idle stay in DECODE_ADDRESS
        pkt_valid = 1'b1; data_in = 2'b11;
        step("discard", S_DA);
        pkt_valid = 1'b0; data_in = 2'b00;
        step("idle", S_DA);

        // Packet to empty fifo 0, four payload bytes
        we_cnt = 0;
        pkt_valid = 1'b1;
        step("p0_lfd", S_LFD);
        for (int i = 0; i < 4; i++) step("p0_ld", S_LD);
        pkt_valid = 1'b0;
        step("p0_lp", S_LP);
        step("p0_cpe", S_CPE);
        step("p0_da", S_DA);
        chk("p0_we_cycles", 8'(we_cnt), 8'd5);

        // Destination 1 not empty -> wait; addr_q, not live data_in, selects
        fifo_empty_1 = 1'b0; pkt_valid = 1'b1; data_in = 2'b01;
        step("w_wte", S_WTE);
        data_in = 2'b00;
        step("w_hold", S_WTE);
        fifo_empty_1 = 1'b1;
        step("w_lfd", S_LFD);
        step("w_ld", S_LD);

        // FIFO full stall and LAF back to LOAD_DATA
        fifo_full = 1'b1;
        step("f_ffs", S_FFS);
        step("f_hold", S_FFS);
        fifo_full = 1'b0;
        step("f_laf", S_LAF);
        step("f_ld", S_LD);

        // Full and end-of-packet together: full wins, then low_pkt_valid -> parity
        fifo_full = 1'b1; pkt_valid = 1'b0;
        step("f2_ffs", S_FFS);
        fifo_full = 1'b0;
        step("f2_laf", S_LAF);
        low_pkt_valid = 1'b1;
        step("f2_lp", S_LP);
        low_pkt_valid = 1'b0; fifo_full = 1'b1;
        step("f2_cpe", S_CPE);
        step("f2_cpe_full", S_FFS);
        fifo_full = 1'b0;
        step("f2_laf2", S_LAF);
        parity_done = 1'b1;
        step("f2_pd_da", S_DA);
        parity_done = 1'b0;

        // Soft reset: only the selected destination counts
        pkt_valid = 1'b1; data_in = 2'b10;
        step("s_lfd", S_LFD);
        step("s_ld", S_LD);
        soft_reset_0 = 1'b1;
        step("s_other_ign", S_LD);
        soft_reset_0 = 1'b0; soft_reset_2 = 1'b1;
        step("s_sel_da", S_DA);
        soft_reset_2 = 1'b0; pkt_valid = 1'b0;
        step("s_idle", S_DA);

        // Hard reset mid-packet
        pkt_valid = 1'b1; data_in = 2'b00;
        step("r_lfd", S_LFD);
        step("r_ld", S_LD);
        reset = 1'b1;
        step("r_da", S_DA);
        reset = 1'b0; pkt_valid = 1'b0;
        step("r_idle", S_DA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
